// File: rtl/ysyx_24100005_mem_arbiter.sv
// ysyx_24100005_mem_arbiter: IFU/LSU arbiter that keeps one memory transaction outstanding, with a response timeout.
// Define YSYX_24100005_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module ysyx_24100005_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              grant_lsu, hs;
`ifdef YSYX_24100005_ARB_RR_EN
  logic last_lsu_q;
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_lsu_q <= 1'b0;
    else if (hs) last_lsu_q <= lsu_req_ready;
`else
  assign grant_lsu = lsu_req_valid;
`endif
  assign lsu_req_ready = (state_q == IDLE) & grant_lsu;
  assign ifu_req_ready = (state_q == IDLE) & ifu_req_valid & ~grant_lsu;
  assign hs            = ifu_req_ready | lsu_req_ready;
  assign mem_req_valid = state_q == REQ;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rvalid    = (state_q == RESP) & ~owner_q;
  assign lsu_rvalid    = (state_q == RESP) & owner_q;
  assign resp_err      = (state_q == RESP) & err_q;
  assign ifu_rdata     = ifu_rvalid ? rdata_q : '0;
  assign lsu_rdata     = lsu_rvalid ? rdata_q : '0;
  // The timeout compares against TIMEOUT so the error pulse lands TIMEOUT+1 cycles after WAIT_RESP entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = REQ;
        owner_d = lsu_req_ready;
        addr_d  = lsu_req_ready ? lsu_addr : ifu_addr;
        wen_d   = lsu_req_ready & lsu_wen;
        wdata_d = lsu_req_ready ? lsu_wdata : '0;
        wmask_d = (lsu_req_ready & lsu_wen) ? lsu_wmask : '0;
      end
      REQ: if (mem_req_ready) begin
        state_d = WAIT_RESP;
        cnt_d   = '0;
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid || cnt_q == CW'(TIMEOUT)) begin
          state_d = RESP;
          err_d   = ~mem_rvalid;
          rdata_d = (mem_rvalid & ~wen_q) ? mem_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// tb_ysyx_24100005_mem_arbiter: directed table vectors plus hand sequences for conflicts, timeout, stall and reset.
module tb_ysyx_24100005_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        resp_err, mem_req_valid, mem_req_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  typedef struct {
    logic        lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    logic        exp_wen;
    logic [7:0]  exp_mask;
  } vec_t;
  vec_t tbl[4];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input vec_t v, input string tag);
    if (v.lsu) begin
      lsu_req_valid = 1'b1;
      lsu_addr = v.addr;
      lsu_wen = v.wen;
      lsu_wdata = v.wdata;
      lsu_wmask = v.wmask;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr = v.addr;
    end
    #1;
    chk({tag, ".ready"}, {ifu_req_ready, lsu_req_ready}, v.lsu ? 2'b01 : 2'b10);
    tick;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    chk({tag, ".mem_req_valid"}, mem_req_valid, 1'b1);
    chk({tag, ".mem_addr"}, mem_addr, v.addr);
    chk({tag, ".mem_wen"}, mem_wen, v.exp_wen);
    chk({tag, ".mem_wmask"}, mem_wmask, v.exp_mask);
    if (v.exp_wen) chk({tag, ".mem_wdata"}, mem_wdata, v.wdata);
    tick;
    chk({tag, ".no_early_rvalid"}, {ifu_rvalid, lsu_rvalid}, 2'b00);
    mem_rvalid = 1'b1;
    mem_rdata = v.mdata;
    tick;
    mem_rvalid = 1'b0;
    chk({tag, ".rvalid"}, {ifu_rvalid, lsu_rvalid}, v.lsu ? 2'b01 : 2'b10);
    chk({tag, ".rdata"}, v.lsu ? lsu_rdata : ifu_rdata, v.exp_rdata);
    chk({tag, ".resp_err"}, resp_err, 1'b0);
    tick;
    chk({tag, ".rvalid_drop"}, {ifu_rvalid, lsu_rvalid}, 2'b00);
  endtask
  initial begin
    tbl[0] = '{1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 32'h0010_0093, 32'h0010_0093, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h5555_AAAA, 32'h0, 1'b1, 8'h0F};
    tbl[2] = '{1'b1, 32'h8000_0200, 1'b0, 32'h1111_1111, 8'hFF, 32'h1234_5678, 32'h1234_5678, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h00, 32'h0020_0113, 32'h0020_0113, 1'b0, 8'h00};
    rst = 1'b0;
    {ifu_req_valid, lsu_req_valid, lsu_wen, mem_req_ready, mem_rvalid} = '0;
    {ifu_addr, lsu_addr, lsu_wdata, mem_rdata} = '0;
    lsu_wmask = '0;
    tick;
    tick;
    chk("reset.ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    chk("reset.rvalid", {ifu_rvalid, lsu_rvalid, resp_err}, 3'b000);
    chk("reset.mem", {mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata}, 74'h0);
    chk("reset.rdata", {ifu_rdata, lsu_rdata}, 64'h0);
    rst = 1'b1;
    mem_req_ready = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) txn(tbl[i], $sformatf("vec%0d", i));
    // Both requesters valid on every IDLE cycle; pointer is IFU-last after vec3.
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0400;
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h8000_0300;
    lsu_wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic exp_l;
`ifdef YSYX_24100005_ARB_RR_EN
      exp_l = (i % 2) == 0;
`else
      exp_l = 1'b1;
`endif
      #1;
      chk($sformatf("conf%0d.ready", i), {ifu_req_ready, lsu_req_ready}, exp_l ? 2'b01 : 2'b10);
      tick;
      chk($sformatf("conf%0d.addr", i), mem_addr, exp_l ? 32'h8000_0300 : 32'h8000_0400);
      chk($sformatf("conf%0d.busy_ready", i), {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h100 + i;
      tick;
      mem_rvalid = 1'b0;
      chk($sformatf("conf%0d.rvalid", i), {ifu_rvalid, lsu_rvalid}, exp_l ? 2'b01 : 2'b10);
      tick;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick;
    // Timeout: no mem_rvalid, error pulse at WAIT entry + 5.
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0500;
    tick;
    ifu_req_valid = 1'b0;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("to.quiet%0d", k), {ifu_rvalid, lsu_rvalid, resp_err}, 3'b000);
      tick;
    end
    chk("to.rvalid", {ifu_rvalid, lsu_rvalid}, 2'b10);
    chk("to.err", resp_err, 1'b1);
    chk("to.rdata", ifu_rdata, 32'h0);
    tick;
    chk("to.idle", {ifu_rvalid, lsu_rvalid, resp_err}, 3'b000);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick;
    mem_rvalid = 1'b0;
    chk("late.ignored", {ifu_rvalid, lsu_rvalid, resp_err}, 3'b000);
    tick;
    chk("late.ignored2", {ifu_rvalid, lsu_rvalid, ifu_rdata}, 34'h0);
    // Downstream stall in REQ, then a response on the last cycle before timeout.
    mem_req_ready = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0800;
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h8000_0600;
    lsu_wen = 1'b1;
    lsu_wdata = 32'hCAFE_F00D;
    lsu_wmask = 8'h3C;
    #1;
    chk("stall.grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
    tick;
    lsu_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d.valid", k), mem_req_valid, 1'b1);
      chk($sformatf("stall%0d.fields", k), {mem_addr, mem_wdata, mem_wmask, mem_wen}, {32'h8000_0600, 32'hCAFE_F00D, 8'h3C, 1'b1});
      chk($sformatf("stall%0d.ready", k), {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick;
    end
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stallw%0d.quiet", k), {ifu_rvalid, lsu_rvalid}, 2'b00);
      tick;
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick;
    mem_rvalid = 1'b0;
    chk("stall.rvalid", {ifu_rvalid, lsu_rvalid}, 2'b01);
    chk("stall.err", resp_err, 1'b0);
    chk("stall.rdata", lsu_rdata, 32'h0);
    tick;
    // Reset asserted during WAIT_RESP aborts the transaction silently.
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0700;
    tick;
    ifu_req_valid = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    chk("rstw.outputs", {mem_req_valid, ifu_rvalid, lsu_rvalid, resp_err, ifu_req_ready, lsu_req_ready}, 6'b0);
    chk("rstw.mem", {mem_addr, mem_wen, mem_wmask}, 41'h0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    tick;
    mem_rvalid = 1'b0;
    rst = 1'b1;
    chk("rstw.no_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b00);
    tick;
    chk("rstw.no_rvalid2", {ifu_rvalid, lsu_rvalid, mem_req_valid}, 3'b000);
    txn('{1'b0, 32'h8000_0900, 1'b0, 32'h0, 8'h00, 32'h0030_0193, 32'h0030_0193, 1'b0, 8'h00}, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
